// File: rtl/scsi_xfer_arbiter_pkg.sv
// Shared types and widths for the SCSI transfer arbiter: FSM state and
// owner encodings, counter widths, and the DMA-readiness qualifier.
package scsi_xfer_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CPU  = 2'b01,
        ST_DMA  = 2'b10,
        ST_GAP  = 2'b11
    } arb_state_t;

    typedef enum logic {
        OWNER_DMA = 1'b0,
        OWNER_CPU = 1'b1
    } owner_t;

    localparam int unsigned BURST_W = 8;
    localparam int unsigned HOLD_W  = 4;

    // The FIFO side that matters depends on direction: FIFO->SCSI needs data, SCSI->FIFO needs room.
    function automatic logic dma_ready(input logic ena, input logic dreq_n, input logic dir,
                                       input logic full, input logic empty);
        return ena & ~dreq_n & (dir ? ~empty : ~full);
    endfunction

endpackage

// File: rtl/scsi_xfer_arbiter_wdog.sv
// CPU-grant watchdog: load/enable counter with a terminal-count strobe.
// Compiled only when SCSI_ARB_WDOG_EN is defined.
`ifdef SCSI_ARB_WDOG_EN
module scsi_xfer_arbiter_wdog #(
    parameter int unsigned CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic enable,
    output logic tc
);

    localparam int unsigned WDOG_W = 10;
    localparam logic [WDOG_W-1:0] LAST = WDOG_W'(CYCLES - 1);

    logic [WDOG_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (enable && (cnt != LAST)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = enable & (cnt == LAST);

endmodule
`endif

// File: rtl/scsi_xfer_arbiter.sv
// Arbitrates the SCSI state machine between CPU register cycles and bounded DMA
// bursts, with a holdoff gap between grants. SCSI_ARB_WDOG_EN adds a CPU-grant watchdog.
module scsi_xfer_arbiter
    import scsi_xfer_arbiter_pkg::*;
#(
    parameter int unsigned BURST_LEN   = 8,
    parameter int unsigned HOLDOFF     = 2,
    parameter int unsigned WDOG_CYCLES = 64
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic       CPUREQ,
    input  logic       DMAENA,
    input  logic       DREQ_,
    input  logic       DMADIR,
    input  logic       FIFOFULL,
    input  logic       FIFOEMPTY,
    input  logic       DACK,
    input  logic       INCBO,
    input  logic       SET_DSACK,
    output logic       CCPUREQ,
    output logic       CDREQ_,
    output logic [1:0] ARB_STATE,
    output logic       WDOG_ERR
);

    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(BURST_LEN);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLDOFF - 1);

    arb_state_t         state;
    owner_t             last_owner;
    logic [BURST_W-1:0] burst_cnt;
    logic [BURST_W-1:0] burst_next;
    logic [HOLD_W-1:0]  hold_cnt;
    logic               cpu_armed;
    logic               wdog_err;
    logic               wdog_tc;
    logic               dma_ok;
    logic               cpu_ok;
    logic               dma_done;

    always_comb begin
        dma_ok     = dma_ready(DMAENA, DREQ_, DMADIR, FIFOFULL, FIFOEMPTY);
        cpu_ok     = CPUREQ & cpu_armed;
        // A byte completing this cycle counts toward the limit before the exit decision.
        burst_next = burst_cnt + BURST_W'(INCBO);
        dma_done   = ~DACK & ((burst_next == BURST_MAX) | ~dma_ok);
    end

`ifdef SCSI_ARB_WDOG_EN
    scsi_xfer_arbiter_wdog #(
        .CYCLES(WDOG_CYCLES)
    ) u_wdog (
        .clk   (CLK),
        .rst_n (nRESET),
        .load  (state != ST_CPU),
        .enable(state == ST_CPU),
        .tc    (wdog_tc)
    );
`else
    // WDOG_CYCLES is never 0 in a legal build, so the timeout never fires.
    assign wdog_tc = (WDOG_CYCLES == 0);
`endif

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state      <= ST_IDLE;
            last_owner <= OWNER_DMA;
            burst_cnt  <= '0;
            hold_cnt   <= '0;
            cpu_armed  <= 1'b1;
            wdog_err   <= 1'b0;
        end else begin
            wdog_err <= 1'b0;
            if (SET_DSACK) begin
                cpu_armed <= 1'b0;
            end else if (!CPUREQ) begin
                cpu_armed <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    // With both pending, the side that did not own last goes first.
                    if (cpu_ok && !(dma_ok && last_owner == OWNER_CPU)) begin
                        state <= ST_CPU;
                    end else if (dma_ok) begin
                        state     <= ST_DMA;
                        burst_cnt <= '0;
                    end
                end
                ST_CPU: begin
                    if (SET_DSACK) begin
                        state      <= ST_GAP;
                        hold_cnt   <= '0;
                        last_owner <= OWNER_CPU;
                    end else if (wdog_tc) begin
                        state      <= ST_GAP;
                        hold_cnt   <= '0;
                        last_owner <= OWNER_CPU;
                        wdog_err   <= 1'b1;
                        cpu_armed  <= 1'b0;
                    end
                end
                ST_DMA: begin
                    burst_cnt <= burst_next;
                    if (dma_done) begin
                        state      <= ST_GAP;
                        hold_cnt   <= '0;
                        last_owner <= OWNER_DMA;
                    end
                end
                ST_GAP: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign CCPUREQ   = (state == ST_CPU);
    assign CDREQ_    = ~((state == ST_DMA) & dma_ok & (burst_cnt < BURST_MAX));
    assign ARB_STATE = state;
    assign WDOG_ERR  = wdog_err;

endmodule

// File: tb/tb_scsi_xfer_arbiter.sv
// Scoreboard bench for scsi_xfer_arbiter: randomized CPU/DMA agents, a phase-level
// reference model, and a negedge monitor comparing DUT outputs against queued expectations.
module tb_scsi_xfer_arbiter;

    localparam int unsigned BL = 8;
    localparam int unsigned HO = 2;
    localparam int unsigned WD = 64;
`ifdef SCSI_ARB_WDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif
    localparam int P_IDLE = 0, P_CPU = 1, P_DMA = 2, P_GAP = 3;

    logic       CLK = 1'b0;
    logic       nRESET = 1'b1;
    logic       CPUREQ = 1'b0, DMAENA = 1'b0, DREQ_ = 1'b1, DMADIR = 1'b0;
    logic       FIFOFULL = 1'b0, FIFOEMPTY = 1'b0, DACK = 1'b0, INCBO = 1'b0, SET_DSACK = 1'b0;
    logic       CCPUREQ, CDREQ_, WDOG_ERR;
    logic [1:0] ARB_STATE;

    scsi_xfer_arbiter #(
        .BURST_LEN  (BL),
        .HOLDOFF    (HO),
        .WDOG_CYCLES(WD)
    ) dut (
        .CLK(CLK), .nRESET(nRESET), .CPUREQ(CPUREQ), .DMAENA(DMAENA), .DREQ_(DREQ_),
        .DMADIR(DMADIR), .FIFOFULL(FIFOFULL), .FIFOEMPTY(FIFOEMPTY), .DACK(DACK),
        .INCBO(INCBO), .SET_DSACK(SET_DSACK), .CCPUREQ(CCPUREQ), .CDREQ_(CDREQ_),
        .ARB_STATE(ARB_STATE), .WDOG_ERR(WDOG_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0] st;
        logic       ccpu;
        logic       cdreq_n;
        logic       wdog;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int errors = 0, checks = 0, cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            chk("arb_state", 32'(ARB_STATE), 32'(mon_e.st));
            chk("ccpureq",   32'(CCPUREQ),   32'(mon_e.ccpu));
            chk("cdreq_n",   32'(CDREQ_),    32'(mon_e.cdreq_n));
            chk("wdog_err",  32'(WDOG_ERR),  32'(mon_e.wdog));
        end
    end

    // Reference model: which requester holds the machine, bytes in this grant, gap time left.
    int m_phase, m_bytes, m_gap_left, m_cpu_cycles;
    bit m_last_cpu, m_armed, m_wdog_pulse;

    task automatic model_reset();
        m_phase = P_IDLE; m_bytes = 0; m_gap_left = 0; m_cpu_cycles = 0;
        m_last_cpu = 1'b0; m_armed = 1'b1; m_wdog_pulse = 1'b0;
    endtask

    function automatic bit dma_ok_now();
        return DMAENA && !DREQ_ && (DMADIR ? !FIFOEMPTY : !FIFOFULL);
    endfunction

    task automatic model_edge();
        bit ok_d, ok_c, new_armed;
        ok_d = dma_ok_now();
        ok_c = CPUREQ && m_armed;
        new_armed = SET_DSACK ? 1'b0 : (!CPUREQ ? 1'b1 : m_armed);
        m_wdog_pulse = 1'b0;
        case (m_phase)
            P_IDLE: begin
                if (ok_c && ok_d) m_phase = m_last_cpu ? P_DMA : P_CPU;
                else if (ok_c)    m_phase = P_CPU;
                else if (ok_d)    m_phase = P_DMA;
                m_bytes = 0;
                m_cpu_cycles = 0;
            end
            P_CPU: begin
                m_cpu_cycles++;
                if (SET_DSACK) begin
                    m_phase = P_GAP; m_gap_left = HO; m_last_cpu = 1'b1;
                end else if (WDOG_ON && m_cpu_cycles == WD) begin
                    m_phase = P_GAP; m_gap_left = HO; m_last_cpu = 1'b1;
                    m_wdog_pulse = 1'b1; new_armed = 1'b0;
                end
            end
            P_DMA: begin
                if (INCBO) m_bytes++;
                if (!DACK && (m_bytes == BL || !ok_d)) begin
                    m_phase = P_GAP; m_gap_left = HO; m_last_cpu = 1'b0;
                end
            end
            default: begin
                m_gap_left--;
                if (m_gap_left == 0) m_phase = P_IDLE;
            end
        endcase
        m_armed = new_armed;
    endtask

    // Stimulus knobs and agent state.
    bit   k_dmaena, k_dir, k_cpu_on, k_cpu_hang;
    int   k_dreq_pct, k_flag_pct, k_full_after = -1, incbo_total;
    int   sm_stage, sm_left, cpu_stage, cpu_wait, cpu_k, cpu_hold;
    logic last_cdreq_n = 1'b1;

    task automatic drive_env();
        DMAENA    = k_dmaena;
        DMADIR    = k_dir;
        DREQ_     = ($urandom_range(0, 99) < k_dreq_pct) ? 1'b0 : 1'b1;
        FIFOFULL  = ($urandom_range(0, 99) < k_flag_pct);
        FIFOEMPTY = ($urandom_range(0, 99) < k_flag_pct);
        if (k_full_after >= 0 && incbo_total >= k_full_after) FIFOFULL = 1'b1;
        // SCSI state machine: a byte starts only after an idle cycle that saw CDREQ_ low.
        INCBO = 1'b0;
        case (sm_stage)
            0: begin
                DACK = !last_cdreq_n;
                if (!last_cdreq_n) begin sm_stage = 1; sm_left = int'($urandom_range(1, 3)); end
            end
            1: begin
                sm_left--;
                if (sm_left == 0) begin DACK = 1'b0; INCBO = 1'b1; incbo_total++; sm_stage = 2; end
            end
            default: begin DACK = 1'b0; sm_stage = 0; end
        endcase
        // CPU bus agent: request, wait for grant, DSACK, then release (possibly late).
        SET_DSACK = 1'b0;
        case (cpu_stage)
            0: begin
                CPUREQ = 1'b0;
                if (k_cpu_on) begin
                    if (cpu_wait == 0) begin
                        CPUREQ = 1'b1; cpu_stage = 1; cpu_k = int'($urandom_range(0, 3));
                    end else cpu_wait--;
                end
            end
            1: begin
                CPUREQ = 1'b1;
                if (k_cpu_hang) begin
                    if (m_wdog_pulse) begin cpu_stage = 2; cpu_hold = int'($urandom_range(0, 4)); end
                end else if (m_phase == P_CPU) begin
                    if (cpu_k == 0) begin
                        SET_DSACK = 1'b1; cpu_stage = 2; cpu_hold = int'($urandom_range(0, 4));
                    end else cpu_k--;
                end
            end
            default: begin
                if (cpu_hold == 0) begin
                    CPUREQ = 1'b0; cpu_stage = 0; cpu_wait = int'($urandom_range(0, 6));
                end else begin
                    CPUREQ = 1'b1; cpu_hold--;
                end
            end
        endcase
    endtask

    task automatic step();
        exp_t e;
        @(posedge CLK);
        #1;
        cyc++;
        model_edge();
        drive_env();
        e.st      = 2'(m_phase);
        e.ccpu    = (m_phase == P_CPU);
        e.cdreq_n = !(m_phase == P_DMA && dma_ok_now() && m_bytes < BL);
        e.wdog    = m_wdog_pulse;
        sbq.push_back(e);
        last_cdreq_n = e.cdreq_n;
    endtask

    task automatic clear_all();
        CPUREQ = 1'b0; DMAENA = 1'b0; DREQ_ = 1'b1; DMADIR = 1'b0; FIFOFULL = 1'b0;
        FIFOEMPTY = 1'b0; DACK = 1'b0; INCBO = 1'b0; SET_DSACK = 1'b0;
        sm_stage = 0; cpu_stage = 0; cpu_wait = 0; last_cdreq_n = 1'b1;
        model_reset();
    endtask

    task automatic set_knobs(input bit ena, input bit dir, input int dreq, input int flag,
                             input bit cpu);
        k_dmaena = ena; k_dir = dir; k_dreq_pct = dreq; k_flag_pct = flag; k_cpu_on = cpu;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, got running, want done");
        $fatal(1);
    end

    initial begin
        bit found;
        clear_all();
        #1 nRESET = 1'b0;
        #2;
        chk("reset_ccpureq", 32'(CCPUREQ), 32'd0);
        chk("reset_cdreq_n", 32'(CDREQ_), 32'd1);
        chk("reset_state", 32'(ARB_STATE), 32'd0);
        chk("reset_wdog", 32'(WDOG_ERR), 32'd0);
        repeat (2) @(negedge CLK);
        #1 nRESET = 1'b1;

        set_knobs(1'b0, 1'b0, 0, 0, 1'b1);                    // CPU only
        repeat (60) step();
        set_knobs(1'b1, 1'b1, 100, 0, 1'b0);                  // full-length bursts, FIFO->SCSI
        repeat (60) step();
        set_knobs(1'b1, 1'b1, 100, 0, 1'b1);                  // contention, alternation
        repeat (150) step();
        set_knobs(1'b1, 1'b0, 100, 0, 1'b0);                  // FIFO fills after 3 bytes
        incbo_total = 0; k_full_after = 3;
        repeat (40) step();
        k_full_after = -1;

        for (int s = 0; s < 20; s++) begin
            set_knobs($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
                      int'($urandom_range(30, 100)), int'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)));
            repeat (100) step();
        end

        // Asynchronous reset in the middle of a DMA byte.
        set_knobs(1'b1, 1'b1, 100, 0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            found = (m_phase == P_DMA) && DACK;
        end
        chk("reach_dma_busy", 32'(found), 32'd1);
        @(negedge CLK);
        #1 nRESET = 1'b0;
        #1;
        chk("midreset_ccpureq", 32'(CCPUREQ), 32'd0);
        chk("midreset_cdreq_n", 32'(CDREQ_), 32'd1);
        chk("midreset_state", 32'(ARB_STATE), 32'd0);
        chk("midreset_wdog", 32'(WDOG_ERR), 32'd0);
        clear_all();
        repeat (2) @(negedge CLK);
        #1 nRESET = 1'b1;

        // CPU grant that never sees DSACK.
        set_knobs(1'b0, 1'b0, 0, 0, 1'b1);
        k_cpu_hang = 1'b1;
        repeat (1000) step();

        @(negedge CLK);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
